// File: rtl/steer_en_gen.sv
// rtl/steer_en_gen.sv - rider-detect and balance-settle steering enable generator
// Optional macro STEER_FAST_SIM_EN shortens the settle terminal count to 2^15-1.
module steer_en_gen #(
    parameter int          LD_W         = 12,
    parameter int unsigned MIN_RIDER_WT = 12'h200,
    parameter int unsigned WT_HYST      = 12'h040,
    parameter int          BAL_SHFT     = 4,
    parameter int          UNBAL_SHFT   = 2,
    parameter int          TMR_W        = 26
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic            tmr_busy
);

    localparam int unsigned ON_THR_I  = MIN_RIDER_WT + WT_HYST;
    localparam int unsigned OFF_THR_I = MIN_RIDER_WT - WT_HYST;
    localparam logic [LD_W:0] ON_THR  = ON_THR_I[LD_W:0];
    localparam logic [LD_W:0] OFF_THR = OFF_THR_I[LD_W:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [LD_W-1:0]   lft_q, lft_d;
    logic [LD_W-1:0]   rght_q, rght_d;
    logic              en_steer_q, en_steer_d;
    logic              rider_off_q, rider_off_d;
    logic              tmr_busy_q, tmr_busy_d;

    logic [LD_W:0]     sum;
    logic [LD_W-1:0]   diff;
    logic              on_cond;
    logic              off_cond;
    logic              bal;
    logic              unbal;
    logic              tc_hit;

    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        if (ld_vld) begin
            lft_d  = lft_ld;
            rght_d = rght_ld;
        end
    end

    // Decisions are made on the captured samples, never on the raw inputs.
    always_comb begin
        sum      = {1'b0, lft_q} + {1'b0, rght_q};
        diff     = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        on_cond  = (sum > ON_THR);
        off_cond = (sum < OFF_THR);
        bal      = ({1'b0, diff} < (sum >> BAL_SHFT));
        unbal    = ({1'b0, diff} > (sum >> UNBAL_SHFT));
    end

`ifdef STEER_FAST_SIM_EN
    always_comb tc_hit = &tmr_q[14:0];
`else
    always_comb tc_hit = &tmr_q;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        case (state_q)
            ST_IDLE: begin
                if (on_cond) begin
                    state_d = ST_WAIT;
                    tmr_d   = '0;
                end
            end
            ST_WAIT: begin
                if (off_cond) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else if (!bal) begin
                    tmr_d = '0;
                end else if (tc_hit) begin
                    state_d = ST_STEER;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_STEER: begin
                if (off_cond) begin
                    state_d = ST_IDLE;
                    tmr_d   = '0;
                end else if (unbal) begin
                    state_d = ST_WAIT;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // Outputs come from the next state so they line up with the state register.
    always_comb begin
        en_steer_d  = (state_d == ST_STEER);
        rider_off_d = (state_d == ST_IDLE);
        tmr_busy_d  = (state_d == ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tmr_q       <= '0;
            lft_q       <= '0;
            rght_q      <= '0;
            en_steer_q  <= 1'b0;
            rider_off_q <= 1'b1;
            tmr_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            lft_q       <= lft_d;
            rght_q      <= rght_d;
            en_steer_q  <= en_steer_d;
            rider_off_q <= rider_off_d;
            tmr_busy_q  <= tmr_busy_d;
        end
    end

    assign en_steer  = en_steer_q;
    assign rider_off = rider_off_q;
    assign tmr_busy  = tmr_busy_q;

endmodule

// File: tb/tb_steer_en_gen.sv
// tb/tb_steer_en_gen.sv - randomized scoreboard bench for steer_en_gen
// Settle timer narrowed to 15 bits so the settle time is 32768 cycles in any build.
module tb_steer_en_gen;

    localparam int TMR_W   = 15;
    localparam int SETTLE  = 1 << TMR_W;
    localparam int ON_THR  = 'h200 + 'h040;
    localparam int OFF_THR = 'h200 - 'h040;
    localparam int M_IDLE  = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STEER = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_vld = 1'b0;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        en_steer;
    logic        rider_off;
    logic        tmr_busy;

    always #5 clk = ~clk;

    steer_en_gen #(
        .LD_W        (12),
        .MIN_RIDER_WT(12'h200),
        .WT_HYST     (12'h040),
        .BAL_SHFT    (4),
        .UNBAL_SHFT  (2),
        .TMR_W       (TMR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .ld_vld   (ld_vld),
        .en_steer (en_steer),
        .rider_off(rider_off),
        .tmr_busy (tmr_busy)
    );

    typedef struct packed {
        logic en;
        logic off;
        logic busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Reference model: mode, count of consecutive balanced cycles, held samples.
    int   m_mode   = M_IDLE;
    int   m_settle = 0;
    int   m_l      = 0;
    int   m_r      = 0;
    logic a_rst    = 1'b0;
    logic a_vld    = 1'b0;
    int   a_l      = 0;
    int   a_r      = 0;

    task automatic model_edge();
        int sum;
        int diff;
        if (!a_rst) return;
        sum  = m_l + m_r;
        diff = (m_l > m_r) ? (m_l - m_r) : (m_r - m_l);
        case (m_mode)
            M_IDLE: begin
                if (sum > ON_THR) begin
                    m_mode   = M_WAIT;
                    m_settle = 0;
                end
            end
            M_WAIT: begin
                if (sum < OFF_THR) begin
                    m_mode = M_IDLE;
                end else if (diff >= sum / 16) begin
                    m_settle = 0;
                end else begin
                    m_settle++;
                    if (m_settle == SETTLE) m_mode = M_STEER;
                end
            end
            default: begin
                if (sum < OFF_THR) begin
                    m_mode = M_IDLE;
                end else if (diff > sum / 4) begin
                    m_mode   = M_WAIT;
                    m_settle = 0;
                end
            end
        endcase
        if (a_vld) begin
            m_l = a_l;
            m_r = a_r;
        end
    endtask

    task automatic step(input logic rst, input logic vld, input int l, input int r);
        exp_t e;
        @(posedge clk);
        model_edge();
        #1;
        rst_n   = rst;
        ld_vld  = vld;
        lft_ld  = l[11:0];
        rght_ld = r[11:0];
        a_rst   = rst;
        a_vld   = vld;
        a_l     = l & 'hFFF;
        a_r     = r & 'hFFF;
        if (!rst) begin
            m_mode   = M_IDLE;
            m_settle = 0;
            m_l      = 0;
            m_r      = 0;
        end
        e.en   = (m_mode == M_STEER);
        e.off  = (m_mode == M_IDLE);
        e.busy = (m_mode == M_WAIT);
        exp_q.push_back(e);
    endtask

    // Valid with the given loads, or an idle cycle with garbage on the bus.
    task automatic feed(input int l, input int r);
        if ($urandom_range(99) < 40) step(1'b1, 1'b1, l, r);
        else step(1'b1, 1'b0, int'($urandom_range(4095)), int'($urandom_range(4095)));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({en_steer, rider_off, tmr_busy} !== {e.en, e.off, e.busy}) begin
                    n_fail++;
                    $display("FAIL outputs cyc=%0d en/off/busy actual=%b%b%b required=%b%b%b",
                             cyc, en_steer, rider_off, tmr_busy, e.en, e.off, e.busy);
                end
            end
        end
    end

    initial begin : driver
        int l;
        int r;
        int d;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0);
        for (int i = 0; i < 200; i++) feed(0, 0);
        step(1'b1, 1'b1, 'h120, 'h120);
        for (int i = 0; i < 300; i++) begin
            l = int'($urandom_range('h120));
            r = int'($urandom_range('h120));
            feed(l, r);
        end

        step(1'b1, 1'b1, 'h130, 'h130);
        for (int i = 0; i < 100; i++) feed('h130, 'h130);
        step(1'b1, 1'b1, 'h130, 'h110);
        for (int i = 0; i < 50; i++) feed('h130, 'h110);
        step(1'b1, 1'b1, 'h130, 'h130);
        for (int i = 0; i < SETTLE + 32; i++) feed('h130, 'h130);

        step(1'b1, 1'b1, 'h0E0, 'h0E0);
        for (int i = 0; i < 50; i++) feed('h0E0, 'h0E0);
        for (int i = 0; i < 200; i++) begin
            l = int'($urandom_range('h400, 'h100));
            d = int'($urandom_range(l / 8));
            r = ($urandom_range(1) == 1) ? l + d : l - d;
            feed(l, r);
        end
        step(1'b1, 1'b1, 'h0DF, 'h0DF);
        for (int i = 0; i < 20; i++) feed('h0DF, 'h0DF);

        step(1'b1, 1'b1, 'h130, 'h130);
        for (int i = 0; i < 20000; i++) feed('h130, 'h130);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 'h130, 'h130);
        for (int i = 0; i < SETTLE + 32; i++) feed('h130, 'h130);
        step(1'b1, 1'b1, 'h200, 'h0C0);
        for (int i = 0; i < 20; i++) feed('h200, 'h0C0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
